// File: rtl/mcdt_fmt_pkg.sv
// Shared types and helpers for the mcdt packet formatter.
// Holds channel count, FSM state encoding and length decode.
package mcdt_fmt_pkg;

    localparam int NUM_CH = 3;
    localparam int LEN_W  = 6;
    localparam int WCNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SEND,
        END
    } fmt_state_e;

    // Packet length in words: 4, 8, 16 or 32.
    function automatic logic [LEN_W-1:0] len_decode(
        input logic [1:0] code
    );
        return 6'd4 << code;
    endfunction

    // Round-robin successor over channels 0..2.
    function automatic logic [1:0] ch_next(
        input logic [1:0] ch
    );
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

endpackage

// File: rtl/mcdt_fmt_fifo.sv
// Per-channel fall-through FIFO: head word visible while not empty.
// Ports: clk, rstn (async, active-high), wr_en/wr_data, rd_en/rd_data,
// count (occupancy), full, empty. A write while full is accepted only
// when a read happens in the same cycle.
module mcdt_fmt_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (count == '0);
    assign full    = count[AW];
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mcdt_formatter.sv
// Buffers the mcdt word stream per channel and emits fixed-length
// packets over a req/grant handshake, one channel at a time.
// Ports: clk, rstn (async, active-high); mcdt_data_i/val_i/id_i input
// stream; fmt_len_i length code; fmt_grant_i downstream accept;
// fmt_req_o/start_o/end_o/data_o/chid_o/length_o packet side;
// fmt_overflow_o, fmt_id_err_o sticky error flags.
module mcdt_formatter
    import mcdt_fmt_pkg::*;
#(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] mcdt_data_i,
    input  logic          mcdt_val_i,
    input  logic [1:0]    mcdt_id_i,
    input  logic [1:0]    fmt_len_i,
    input  logic          fmt_grant_i,
    output logic          fmt_req_o,
    output logic          fmt_start_o,
    output logic          fmt_end_o,
    output logic [DW-1:0] fmt_data_o,
    output logic [1:0]    fmt_chid_o,
    output logic [5:0]    fmt_length_o,
    output logic [2:0]    fmt_overflow_o,
    output logic          fmt_id_err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    fmt_state_e        state;
    logic [1:0]        chid_q;
    logic [LEN_W-1:0]  len_q;
    logic [WCNT_W-1:0] wcnt;
    logic [1:0]        rr_ptr;

    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] rd_en;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [DW-1:0]     head  [NUM_CH];
    logic [CW-1:0]     count [NUM_CH];

    logic [LEN_W-1:0]  req_len;
    logic [3:0]        elig;
    logic              pick_vld;
    logic [1:0]        pick_ch;
    logic              sending;
    logic              last_word;
    logic [DW-1:0]     sel_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
        mcdt_fmt_fifo #(
            .DW    (DW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .wr_en   (wr_en[c]),
            .wr_data (mcdt_data_i),
            .rd_en   (rd_en[c]),
            .rd_data (head[c]),
            .count   (count[c]),
            .full    (full[c]),
            .empty   (empty[c])
        );
    end

    assign sending   = (state == SEND);
    assign req_len   = len_decode(fmt_len_i);
    assign last_word = (wcnt == WCNT_W'(len_q - 6'd1));

    always_comb begin
        wr_en = '0;
        rd_en = '0;
        elig  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_en[c] = mcdt_val_i && (mcdt_id_i == 2'(c));
            rd_en[c] = sending && (chid_q == 2'(c));
            elig[c]  = (count[c] >= CW'(req_len));
        end
    end

    // Search starts at the channel after the last one served.
    always_comb begin
        logic [1:0] cand;
        pick_vld = 1'b0;
        pick_ch  = rr_ptr;
        cand     = rr_ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!pick_vld && elig[cand]) begin
                pick_vld = 1'b1;
                pick_ch  = cand;
            end
            cand = ch_next(cand);
        end
    end

    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (chid_q == 2'(c)) sel_data = head[c];
        end
    end

    assign fmt_data_o   = sending ? sel_data : '0;
    assign fmt_start_o  = sending && (wcnt == '0);
    assign fmt_end_o    = sending && last_word;
    assign fmt_chid_o   = chid_q;
    assign fmt_length_o = len_q;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= IDLE;
            chid_q    <= '0;
            len_q     <= '0;
            wcnt      <= '0;
            rr_ptr    <= '0;
            fmt_req_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state     <= REQ;
                        chid_q    <= pick_ch;
                        len_q     <= req_len;
                        rr_ptr    <= ch_next(pick_ch);
                        fmt_req_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (fmt_grant_i) begin
                        state     <= SEND;
                        wcnt      <= '0;
                        fmt_req_o <= 1'b0;
                    end
                end
                SEND: begin
                    if (last_word) begin
                        state  <= END;
                        chid_q <= '0;
                        len_q  <= '0;
                        wcnt   <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A push into a full FIFO is kept only if that FIFO pops this cycle.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            fmt_overflow_o <= '0;
            fmt_id_err_o   <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en[c] && full[c] && !rd_en[c])
                    fmt_overflow_o[c] <= 1'b1;
            end
            if (mcdt_val_i && (mcdt_id_i == 2'd3))
                fmt_id_err_o <= 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^empty;

endmodule

// File: tb/tb_mcdt_formatter.sv
// Self-checking bench for mcdt_formatter: vector table, directed
// corner sequences and random traffic against a queue-based model.
module tb_mcdt_formatter;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] mcdt_data_i = '0;
    logic        mcdt_val_i = 1'b0;
    logic [1:0]  mcdt_id_i = '0;
    logic [1:0]  fmt_len_i = '0;
    logic        fmt_grant_i = 1'b0;
    logic        fmt_req_o;
    logic        fmt_start_o;
    logic        fmt_end_o;
    logic [31:0] fmt_data_o;
    logic [1:0]  fmt_chid_o;
    logic [5:0]  fmt_length_o;
    logic [2:0]  fmt_overflow_o;
    logic        fmt_id_err_o;

    mcdt_formatter #(.DW(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .mcdt_data_i    (mcdt_data_i),
        .mcdt_val_i     (mcdt_val_i),
        .mcdt_id_i      (mcdt_id_i),
        .fmt_len_i      (fmt_len_i),
        .fmt_grant_i    (fmt_grant_i),
        .fmt_req_o      (fmt_req_o),
        .fmt_start_o    (fmt_start_o),
        .fmt_end_o      (fmt_end_o),
        .fmt_data_o     (fmt_data_o),
        .fmt_chid_o     (fmt_chid_o),
        .fmt_length_o   (fmt_length_o),
        .fmt_overflow_o (fmt_overflow_o),
        .fmt_id_err_o   (fmt_id_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: per-channel word queues plus packet phase
    // (0 idle, 1 request, 2 sending, 3 gap).
    logic [31:0] mq [3][$];
    int          m_phase, m_ch, m_len, m_idx, m_rr;
    logic [2:0]  m_ovf;
    logic        m_iderr;

    logic [31:0] got_w[$];
    int          got_ch[$];
    int          got_len[$];
    logic [31:0] exp_w[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++) mq[c].delete();
        m_phase = 0;
        m_ch = 0;
        m_len = 0;
        m_idx = 0;
        m_rr = 0;
        m_ovf = '0;
        m_iderr = 1'b0;
    endtask

    task automatic model_edge();
        int sz[3];
        bit pop;
        int pch;
        int need;
        int id;
        for (int c = 0; c < 3; c++) sz[c] = mq[c].size();
        pop = (m_phase == 2);
        pch = m_ch;
        need = 4 << int'(fmt_len_i);
        case (m_phase)
            0: begin
                for (int k = 0; k < 3; k++) begin
                    int c;
                    c = (m_rr + k) % 3;
                    if (m_phase == 0 && sz[c] >= need) begin
                        m_phase = 1;
                        m_ch = c;
                        m_len = need;
                    end
                end
            end
            1: if (fmt_grant_i) begin
                m_phase = 2;
                m_idx = 0;
            end
            2: if (m_idx == m_len - 1) begin
                m_phase = 3;
                m_rr = (m_ch + 1) % 3;
            end else begin
                m_idx++;
            end
            default: m_phase = 0;
        endcase
        if (pop) void'(mq[pch].pop_front());
        if (mcdt_val_i) begin
            id = int'(mcdt_id_i);
            if (id == 3) m_iderr = 1'b1;
            else if (sz[id] == DEPTH && !(pop && pch == id)) m_ovf[id] = 1'b1;
            else mq[id].push_back(mcdt_data_i);
        end
    endtask

    task automatic model_check();
        bit snd;
        logic [31:0] ed;
        snd = (m_phase == 2);
        ed = (snd && mq[m_ch].size() > 0) ? mq[m_ch][0] : 32'h0;
        chk("req", 64'(fmt_req_o), 64'(m_phase == 1));
        chk("start", 64'(fmt_start_o), 64'(snd && m_idx == 0));
        chk("end", 64'(fmt_end_o), 64'(snd && m_idx == m_len - 1));
        chk("data", 64'(fmt_data_o), 64'(ed));
        chk("chid", 64'(fmt_chid_o),
            64'((m_phase == 1 || m_phase == 2) ? m_ch : 0));
        chk("length", 64'(fmt_length_o),
            64'((m_phase == 1 || m_phase == 2) ? m_len : 0));
        chk("overflow", 64'(fmt_overflow_o), 64'(m_ovf));
        chk("id_err", 64'(fmt_id_err_o), 64'(m_iderr));
    endtask

    task automatic cycle(input logic v, input logic [1:0] id,
                         input logic [31:0] d, input logic g,
                         input logic [1:0] l);
        mcdt_val_i = v;
        mcdt_id_i = id;
        mcdt_data_i = d;
        fmt_grant_i = g;
        fmt_len_i = l;
        @(posedge clk);
        model_edge();
        #1;
        model_check();
        if (fmt_start_o) begin
            got_ch.push_back(int'(fmt_chid_o));
            got_len.push_back(int'(fmt_length_o));
        end
        if (fmt_length_o != 0 && !fmt_req_o) got_w.push_back(fmt_data_o);
    endtask

    task automatic idle(input int n, input logic g, input logic [1:0] l);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'h0, g, l);
    endtask

    task automatic cap_clear();
        got_w.delete();
        got_ch.delete();
        got_len.delete();
        exp_w.delete();
    endtask

    task automatic check_cap(input string nm);
        chk({nm, "_nwords"}, 64'(got_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            chk({nm, "_word"}, 64'(got_w[i]), 64'(exp_w[i]));
    endtask

    task automatic check_zero_outs(input string nm);
        chk({nm, "_req"}, 64'(fmt_req_o), 64'd0);
        chk({nm, "_start"}, 64'(fmt_start_o), 64'd0);
        chk({nm, "_end"}, 64'(fmt_end_o), 64'd0);
        chk({nm, "_data"}, 64'(fmt_data_o), 64'd0);
        chk({nm, "_chid"}, 64'(fmt_chid_o), 64'd0);
        chk({nm, "_length"}, 64'(fmt_length_o), 64'd0);
        chk({nm, "_ovf"}, 64'(fmt_overflow_o), 64'd0);
        chk({nm, "_iderr"}, 64'(fmt_id_err_o), 64'd0);
    endtask

    task automatic do_reset();
        mcdt_val_i = 1'b0;
        fmt_grant_i = 1'b0;
        rstn = 1'b1;
        model_clear();
        cap_clear();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outs("reset");
        rstn = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        req;
        logic        st;
        logic        en;
        logic [31:0] data;
        logic [5:0]  len;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [31:0] d;
        int guard;

        // Single ch0 packet, len code 0, grant tied high.
        tbl[0]  = '{1, 32'h00C0_0000, 0, 0, 0, 32'h0, 6'd0};
        tbl[1]  = '{1, 32'h00C0_0001, 0, 0, 0, 32'h0, 6'd0};
        tbl[2]  = '{1, 32'h00C0_0002, 0, 0, 0, 32'h0, 6'd0};
        tbl[3]  = '{1, 32'h00C0_0003, 0, 0, 0, 32'h0, 6'd0};
        tbl[4]  = '{0, 32'h0, 1, 0, 0, 32'h0, 6'd4};
        tbl[5]  = '{0, 32'h0, 0, 1, 0, 32'h00C0_0000, 6'd4};
        tbl[6]  = '{0, 32'h0, 0, 0, 0, 32'h00C0_0001, 6'd4};
        tbl[7]  = '{0, 32'h0, 0, 0, 0, 32'h00C0_0002, 6'd4};
        tbl[8]  = '{0, 32'h0, 0, 0, 1, 32'h00C0_0003, 6'd4};
        tbl[9]  = '{0, 32'h0, 0, 0, 0, 32'h0, 6'd0};
        tbl[10] = '{0, 32'h0, 0, 0, 0, 32'h0, 6'd0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, 2'd0, tbl[i].d, 1'b1, 2'd0);
            chk("tbl_req", 64'(fmt_req_o), 64'(tbl[i].req));
            chk("tbl_start", 64'(fmt_start_o), 64'(tbl[i].st));
            chk("tbl_end", 64'(fmt_end_o), 64'(tbl[i].en));
            chk("tbl_data", 64'(fmt_data_o), 64'(tbl[i].data));
            chk("tbl_length", 64'(fmt_length_o), 64'(tbl[i].len));
            chk("tbl_chid", 64'(fmt_chid_o), 64'd0);
        end

        // Round robin: three channels queued before the first grant.
        do_reset();
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 4; k++)
                cycle(1'b1, 2'(c), 32'h00C0_0000 | (c << 16) | k, 1'b0, 2'd0);
        for (int k = 4; k < 8; k++)
            cycle(1'b1, 2'd0, 32'h00C0_0000 | k, 1'b0, 2'd0);
        idle(40, 1'b1, 2'd0);
        for (int k = 0; k < 4; k++) exp_w.push_back(32'h00C0_0000 | k);
        for (int k = 0; k < 4; k++) exp_w.push_back(32'h00C1_0000 | k);
        for (int k = 0; k < 4; k++) exp_w.push_back(32'h00C2_0000 | k);
        for (int k = 4; k < 8; k++) exp_w.push_back(32'h00C0_0000 | k);
        check_cap("rr");
        chk("rr_npkt", 64'(got_ch.size()), 64'd4);
        if (got_ch.size() == 4) begin
            chk("rr_ch0", 64'(got_ch[0]), 64'd0);
            chk("rr_ch1", 64'(got_ch[1]), 64'd1);
            chk("rr_ch2", 64'(got_ch[2]), 64'd2);
            chk("rr_ch3", 64'(got_ch[3]), 64'd0);
        end

        // Overflow on ch1, then one 32-word packet.
        do_reset();
        for (int k = 0; k < 33; k++)
            cycle(1'b1, 2'd1, 32'h00C1_0000 | k, 1'b0, 2'd3);
        chk("ovf_flag", 64'(fmt_overflow_o), 64'b010);
        idle(40, 1'b1, 2'd3);
        for (int k = 0; k < 32; k++) exp_w.push_back(32'h00C1_0000 | k);
        check_cap("ovf");
        chk("ovf_npkt", 64'(got_ch.size()), 64'd1);
        if (got_len.size() > 0) chk("ovf_len", 64'(got_len[0]), 64'd32);

        // Delayed grant with a length-code change while requesting.
        do_reset();
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 2'd0, 32'h00D0_0000 | k, 1'b0, 2'd0);
        guard = 0;
        while (!fmt_req_o && guard < 5) begin
            idle(1, 1'b0, 2'd0);
            guard++;
        end
        chk("dg_req_seen", 64'(fmt_req_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            idle(1, 1'b0, 2'd3);
            chk("dg_req_hold", 64'(fmt_req_o), 64'd1);
            chk("dg_len_hold", 64'(fmt_length_o), 64'd4);
        end
        idle(10, 1'b1, 2'd3);
        for (int k = 0; k < 4; k++) exp_w.push_back(32'h00D0_0000 | k);
        check_cap("dg");

        // Invalid id, then push into full ch2 while it is being drained.
        do_reset();
        cycle(1'b1, 2'd3, 32'hDEAD_BEEF, 1'b0, 2'd0);
        chk("iderr_set", 64'(fmt_id_err_o), 64'd1);
        idle(4, 1'b0, 2'd0);
        chk("iderr_noreq", 64'(fmt_req_o), 64'd0);
        for (int k = 0; k < 32; k++)
            cycle(1'b1, 2'd2, 32'h00C2_0000 | k, 1'b0, 2'd0);
        chk("full_noovf", 64'(fmt_overflow_o), 64'd0);
        idle(1, 1'b1, 2'd0);
        for (int k = 32; k < 36; k++)
            cycle(1'b1, 2'd2, 32'h00C2_0000 | k, 1'b1, 2'd0);
        chk("conc_noovf", 64'(fmt_overflow_o), 64'd0);
        idle(80, 1'b1, 2'd0);
        for (int k = 0; k < 36; k++) exp_w.push_back(32'h00C2_0000 | k);
        check_cap("conc");
        chk("conc_iderr_sticky", 64'(fmt_id_err_o), 64'd1);

        // Asynchronous reset in the middle of a ch1 packet.
        do_reset();
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 2'd1, 32'h00E1_0000 | k, 1'b1, 2'd0);
        guard = 0;
        while (!fmt_start_o && guard < 10) begin
            idle(1, 1'b1, 2'd0);
            guard++;
        end
        chk("mr_start_seen", 64'(fmt_start_o), 64'd1);
        idle(1, 1'b1, 2'd0);
        chk("mr_word1", 64'(fmt_data_o), 64'h00E1_0001);
        #2;
        rstn = 1'b1;
        #1;
        check_zero_outs("mr_async");
        model_clear();
        cap_clear();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 2'd2, 32'h00F2_0000 | k, 1'b0, 2'd1);
            cycle(1'b1, 2'd0, 32'h00F0_0000 | k, 1'b0, 2'd1);
        end
        idle(1, 1'b0, 2'd0);
        chk("mr_req", 64'(fmt_req_o), 64'd1);
        chk("mr_rr_ch0", 64'(fmt_chid_o), 64'd0);
        idle(20, 1'b1, 2'd0);
        for (int k = 0; k < 4; k++) exp_w.push_back(32'h00F0_0000 | k);
        for (int k = 0; k < 4; k++) exp_w.push_back(32'h00F2_0000 | k);
        check_cap("mr");

        // Random traffic against the model.
        do_reset();
        begin
            logic [1:0] l;
            logic [1:0] id;
            l = 2'd0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(15) == 0) l = 2'($urandom_range(3));
                id = ($urandom_range(19) == 0) ? 2'd3 : 2'($urandom_range(2));
                d = $urandom;
                cycle($urandom_range(3) != 0, id, d, $urandom_range(3) != 0, l);
            end
            idle(200, 1'b1, 2'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcdt_formatter.md
# mcdt_formatter

Downstream consumer of the `mcdt` multi-channel data transfer block. It accepts the arbitrated `mcdt_data/val/id` word stream, which has no backpressure, and buffers the words per channel. It then emits fixed-length packets, one channel at a time, over a req/grant handshake to the next stage (packet sink or off-chip link). Packet length is selectable at run time.

## Interface
Parameters:
- `DW`, 32, data width.
- `FIFO_DEPTH`, 32, words per channel FIFO; power of 2, ≥32.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-high.
- `mcdt_data_i`  in  DW  word from mcdt.
- `mcdt_val_i`  in  1  word valid, one word per cycle max.
- `mcdt_id_i`  in  2  source channel 0..2.
- `fmt_len_i`  in  2  packet length code: 0→4, 1→8, 2→16, 3→32 words.
- `fmt_grant_i`  in  1  downstream accepts pending request.
- `fmt_req_o`  out  1  packet ready, waiting for grant.
- `fmt_start_o`  out  1  first word of packet.
- `fmt_end_o`  out  1  last word of packet.
- `fmt_data_o`  out  DW  packet word.
- `fmt_chid_o`  out  2  channel of current packet.
- `fmt_length_o`  out  6  length of current packet, in words.
- `fmt_overflow_o`  out  3  sticky per-channel overflow.
- `fmt_id_err_o`  out  1  sticky, `mcdt_val_i` seen with `id==3`.

## Operation
- Push: on `mcdt_val_i=1`, write `mcdt_data_i` into FIFO[`mcdt_id_i`].
  - Target full: drop the word and set `fmt_overflow_o[id]`.
  - `id==3`: drop the word and set `fmt_id_err_o`.
  - Sticky flags clear only on reset.
- Eligible channel: FIFO count ≥ decoded length of the current `fmt_len_i`.
- FSM states:
  - IDLE: if any channel is eligible, pick one round-robin, starting at the channel after the last one served. After reset, ch0 has highest priority. Latch chid, length and byte-free length code, then go to REQ.
  - REQ: `fmt_req_o=1`. Stay until `fmt_grant_i=1` is sampled at a clock edge, then go to SEND.
  - SEND: each cycle pop one word from the latched FIFO and present it.
    - `fmt_start_o=1` on word 0; `fmt_end_o=1` on word length−1.
    - After the last word, go to END.
  - END: one idle cycle with all packet outputs 0, then IDLE.
- `fmt_len_i` is sampled only in IDLE. Changes during REQ/SEND/END have no effect on the packet in progress.
- Underflow cannot occur: eligibility guarantees enough words.
- Simultaneous push and pop on the same FIFO is legal; count is unchanged, including when the FIFO is full (no overflow).
- Arithmetic: length is (4 << code), held in 6 bits. The word counter is 5 bits and compares against length−1.

## Timing
- Reset values: `fmt_req_o`, `fmt_start_o`, `fmt_end_o`, `fmt_data_o`, `fmt_chid_o`, `fmt_length_o`, `fmt_overflow_o`, `fmt_id_err_o` are all 0. All FIFOs are empty. State is IDLE. Round-robin pointer is set so ch0 is next.
- Assertion of `rstn` mid-packet aborts the packet immediately and asynchronously. Buffered words are discarded.
- Push is registered: a word sampled at edge P counts toward eligibility in the cycle after P.
- IDLE→REQ transition at edge P+1; `fmt_req_o` is high after P+1.
- Grant sampled at edge G: word 0 is presented in the cycle after G.
- `fmt_data_o`, `fmt_start_o`, `fmt_end_o` are combinational from FIFO head, state and counter. They are 0 outside SEND.
- `fmt_chid_o` and `fmt_length_o` hold from REQ through SEND and are 0 in IDLE/END.
- Minimum gap between packets: one END cycle plus one IDLE cycle.
- With grant tied high, back-to-back packets occur every length+3 cycles.

## Structure
- Package `mcdt_fmt_pkg`:
  - `NUM_CH=3`.
  - `fmt_state_e` enum: IDLE, REQ, SEND, END.
  - Function `len_decode(code)` → 6-bit word count.
- Sub-module `mcdt_fmt_fifo`: synchronous fall-through FIFO with count output and async reset. Instantiated `NUM_CH` times.
- The top holds push demux, eligibility, round-robin pick, FSM, word counter and sticky flags.

## Test plan
- Single packet: `fmt_len_i=0`, grant tied 1, push ch0 `0x00C0_0000..0x00C0_0003` on consecutive cycles → `fmt_req_o` one cycle, then 4 words `0x00C0_0000..3`, start on word 0, end on word 3, chid 0, length 4.
- Round-robin: ch0, ch1, ch2 each hold 4 words before the first grant; push 4 more to ch0 → packets in order ch0, ch1, ch2, ch0, each `0x00Cn_000k` in order.
- Overflow: grant 0, push 33 words to ch1 → `fmt_overflow_o=3'b010` after the 33rd push. Then grant 1 with `fmt_len_i=3` → one 32-word packet `0x00C1_0000..0x00C1_001F`.
- Delayed grant: grant low for 5 cycles while `fmt_req_o=1`; change `fmt_len_i` 0→3 during REQ → request held steady, packet still 4 words.
- Invalid id and concurrency: push `id=3` → `fmt_id_err_o=1`, no FIFO change. Push ch2 during a ch2 SEND at full → no overflow, order preserved.
- Reset mid-SEND: assert `rstn` after word 1 → all outputs 0 immediately. After release, the next eligible packet starts from ch0.
